// File: rtl/x_array_comparator_counter_if.sv
// Bus bundle for the GF(p) divider termination/result-select unit.
// The slave side is the comparator/counter block; the master side is
// whatever owns the u/v/x1/x2 datapath registers and the start strobe.
interface x_array_comparator_counter_if;

    logic         start;
    logic [255:0] u;
    logic [255:0] v;
    logic [255:0] x1;
    logic [255:0] x2;
    logic         comp_u;
    logic         comp_v;
    logic         hold_en;
    logic [9:0]   counter;
    logic         done;
    logic [255:0] result;

    modport master (
        output start,
        output u,
        output v,
        output x1,
        output x2,
        input  comp_u,
        input  comp_v,
        input  hold_en,
        input  counter,
        input  done,
        input  result
    );

    modport slave (
        input  start,
        input  u,
        input  v,
        input  x1,
        input  x2,
        output comp_u,
        output comp_v,
        output hold_en,
        output counter,
        output done,
        output result
    );

endinterface

// File: rtl/x_array_comparator_counter.sv
// Termination and result-select unit for the 256-bit binary GF(p)
// divider/inverter. Detects u == 1 / v == 1 to stop the iteration,
// picks the final quotient (x2 wins over x1), and runs a mod-512
// down counter that bounds the iteration window. The result is only
// presented while the counter sits at zero; otherwise it reads 0.
module x_array_comparator_counter (
    input  logic                             i_clk,
    input  logic                             i_rst,
    x_array_comparator_counter_if.slave      if_bus
);

    localparam logic [255:0] LP_ONE        = 256'd1;
    localparam logic [9:0]   LP_COUNT_LOAD = 10'd511;

    logic         w_comp_u;
    logic         w_comp_v;
    logic         w_hold_en;
    logic [255:0] w_sel_x1;
    logic [255:0] w_sel;
    logic [255:0] w_result;
    logic [9:0]   r_counter;
    logic         r_done;

    // Bit-exact compare of u and v against one; either hit freezes the datapath
    always_comb begin
        w_comp_u  = (if_bus.u == LP_ONE);
        w_comp_v  = (if_bus.v == LP_ONE);
        w_hold_en = ~(w_comp_u | w_comp_v);
    end

    // X_Array gating stage: every x1 bit ANDed with the u == 1 flag
    always_comb begin
        w_sel_x1 = if_bus.x1 & {256{w_comp_u}};
    end

    // Quotient select (v == 1 has priority) and zero-forcing while counting
    always_comb begin
        w_sel    = w_comp_v ? if_bus.x2 : w_sel_x1;
        w_result = r_done ? w_sel : '0;
    end

    // Saturating down counter with done kept as a register alongside it
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_counter <= '0;
            r_done    <= 1'b1;
        end else if (if_bus.start) begin
            r_counter <= LP_COUNT_LOAD;
            r_done    <= 1'b0;
        end else if (r_counter != 10'd0) begin
            r_counter <= r_counter - 10'd1;
            r_done    <= (r_counter == 10'd1);
        end else begin
            r_counter <= r_counter;
            r_done    <= 1'b1;
        end
    end

    assign if_bus.comp_u  = w_comp_u;
    assign if_bus.comp_v  = w_comp_v;
    assign if_bus.hold_en = w_hold_en;
    assign if_bus.counter = r_counter;
    assign if_bus.done    = r_done;
    assign if_bus.result  = w_result;

endmodule

// File: tb/tb_x_array_comparator_counter.sv
// Self-checking bench for x_array_comparator_counter: counter sequencing,
// reset/start priority, comparator edge values, result select and gating,
// and a randomized wide-compare sweep scored through an expectation queue.
module tb_x_array_comparator_counter;

    typedef struct {
        logic         compU;
        logic         compV;
        logic         holdEn;
        logic [255:0] result;
    } exp_t;

    logic clk;
    logic rst;
    int   numChecks;
    int   numErrors;
    exp_t expQueue[$];

    x_array_comparator_counter_if bus ();

    x_array_comparator_counter dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .if_bus (bus)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something stalls
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, errors %0d", numErrors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    // Independent reference for the combinational outputs
    function automatic exp_t refModel(input logic [255:0] u, input logic [255:0] v,
                                      input logic [255:0] x1, input logic [255:0] x2,
                                      input logic doneNow);
        exp_t e;
        logic [255:0] one;
        one      = 256'd1;
        e.compU  = (u === one);
        e.compV  = (v === one);
        e.holdEn = !(e.compU || e.compV);
        if (!doneNow)     e.result = '0;
        else if (e.compV) e.result = x2;
        else if (e.compU) e.result = x1;
        else              e.result = '0;
        return e;
    endfunction

    function automatic logic [255:0] randWide();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reset clears the counter and raises done
    task automatic test_reset();
        bus.start = 1'b0;
        bus.u = '0; bus.v = '0; bus.x1 = '0; bus.x2 = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        numChecks++;
        if (bus.counter !== 10'd0) begin
            numErrors++;
            $display("[TB] FAIL reset_counter: got %0d expected 0", bus.counter);
        end
        numChecks++;
        if (bus.done !== 1'b1) begin
            numErrors++;
            $display("[TB] FAIL reset_done: got %b expected 1", bus.done);
        end
    endtask

    // Start pulse loads 511, then 511 decrements to zero and saturation
    task automatic test_counter();
        int bad;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        numChecks++;
        if (bus.counter !== 10'd511 || bus.done !== 1'b0) begin
            numErrors++;
            $display("[TB] FAIL start_load: got counter %0d done %b expected 511 done 0", bus.counter, bus.done);
        end
        bad = 0;
        for (int k = 1; k <= 510; k++) begin
            @(posedge clk); #1;
            if (bus.counter !== 10'(511 - k) || bus.done !== 1'b0) bad++;
        end
        numChecks++;
        if (bad != 0) begin
            numErrors++;
            $display("[TB] FAIL count_down: %0d cycles wrong, last counter %0d expected 1", bad, bus.counter);
        end
        @(posedge clk); #1;
        numChecks++;
        if (bus.counter !== 10'd0 || bus.done !== 1'b1) begin
            numErrors++;
            $display("[TB] FAIL count_end: got counter %0d done %b expected 0 done 1", bus.counter, bus.done);
        end
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (bus.counter !== 10'd0 || bus.done !== 1'b1) bad++;
        end
        numChecks++;
        if (bad != 0) begin
            numErrors++;
            $display("[TB] FAIL count_saturate: %0d cycles wrong, counter %0d expected 0", bad, bus.counter);
        end
    endtask

    // Comparator edge values, scored through the queue
    task automatic test_comparators();
        logic [255:0] uTab [3];
        logic [255:0] vTab [3];
        exp_t e;
        uTab[0] = 256'd1;  vTab[0] = 256'd5;
        uTab[1] = '1;      vTab[1] = 256'd0;
        uTab[2] = (256'd1 << 255) + 256'd1; vTab[2] = 256'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.u = uTab[i]; bus.v = vTab[i]; bus.x1 = 256'h55; bus.x2 = 256'hAA;
            expQueue.push_back(refModel(uTab[i], vTab[i], 256'h55, 256'hAA, 1'b1));
            #1;
            e = expQueue.pop_front();
            numChecks++;
            if (bus.comp_u !== e.compU || bus.comp_v !== e.compV || bus.hold_en !== e.holdEn) begin
                numErrors++;
                $display("[TB] FAIL comparators[%0d]: got u%b v%b hold%b expected u%b v%b hold%b",
                         i, bus.comp_u, bus.comp_v, bus.hold_en, e.compU, e.compV, e.holdEn);
            end
        end
    endtask

    // Result select with done high: x1, then x2 priority, then neither
    task automatic test_result_select();
        logic [255:0] uTab [3];
        logic [255:0] vTab [3];
        logic [255:0] want [3];
        uTab[0] = 256'd1; vTab[0] = 256'd7; want[0] = 256'h1234;
        uTab[1] = 256'd1; vTab[1] = 256'd1; want[1] = 256'hABCD;
        uTab[2] = 256'd3; vTab[2] = 256'd9; want[2] = 256'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.u = uTab[i]; bus.v = vTab[i]; bus.x1 = 256'h1234; bus.x2 = 256'hABCD;
            #1;
            numChecks++;
            if (bus.result !== want[i]) begin
                numErrors++;
                $display("[TB] FAIL result_select[%0d]: got %h expected %h", i, bus.result, want[i]);
            end
        end
    endtask

    // Result stays zero while counting, then presents x1
    task automatic test_gating();
        int bad;
        bus.u = 256'd1; bus.v = 256'd0; bus.x1 = 256'h1234; bus.x2 = 256'hABCD;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        numChecks++;
        if (bus.hold_en !== 1'b0) begin
            numErrors++;
            $display("[TB] FAIL gating_hold: got %b expected 0", bus.hold_en);
        end
        bad = (bus.result !== 256'd0) ? 1 : 0;
        for (int k = 1; k < 511; k++) begin
            @(posedge clk); #1;
            if (bus.result !== 256'd0) bad++;
        end
        numChecks++;
        if (bad != 0) begin
            numErrors++;
            $display("[TB] FAIL gating_zero: %0d counting cycles had nonzero result", bad);
        end
        @(posedge clk); #1;
        numChecks++;
        if (bus.result !== 256'h1234) begin
            numErrors++;
            $display("[TB] FAIL gating_release: got %h expected 1234", bus.result);
        end
    endtask

    // Reset beats start; start reloads mid-count
    task automatic test_priority();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (311) @(posedge clk);
        #1;
        numChecks++;
        if (bus.counter !== 10'd200) begin
            numErrors++;
            $display("[TB] FAIL prio_at200: got %0d expected 200", bus.counter);
        end
        rst = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.start = 1'b0;
        numChecks++;
        if (bus.counter !== 10'd0 || bus.done !== 1'b1) begin
            numErrors++;
            $display("[TB] FAIL prio_rst_over_start: got counter %0d done %b expected 0 done 1", bus.counter, bus.done);
        end
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (411) @(posedge clk);
        #1;
        numChecks++;
        if (bus.counter !== 10'd100) begin
            numErrors++;
            $display("[TB] FAIL prio_at100: got %0d expected 100", bus.counter);
        end
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        numChecks++;
        if (bus.counter !== 10'd511 || bus.done !== 1'b0) begin
            numErrors++;
            $display("[TB] FAIL prio_reload: got counter %0d done %b expected 511 done 0", bus.counter, bus.done);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Random wide vectors with injected 1 and 1 +/- 2^k values
    task automatic test_wide_compare();
        logic [255:0] u, v, x1, x2;
        exp_t e;
        int bad;
        bad = 0;
        for (int i = 0; i < 1200; i++) begin
            u  = randWide();
            v  = randWide();
            x1 = randWide();
            x2 = randWide();
            case (i % 6)
                0: u = 256'd1;
                1: v = 256'd1;
                2: begin u = 256'd1; v = 256'd1; end
                3: u = 256'd1 + (256'd1 << $urandom_range(0, 255));
                4: v = 256'd1 - (256'd1 << $urandom_range(0, 255));
                default: ;
            endcase
            @(negedge clk);
            bus.u = u; bus.v = v; bus.x1 = x1; bus.x2 = x2;
            expQueue.push_back(refModel(u, v, x1, x2, 1'b1));
            #1;
            e = expQueue.pop_front();
            numChecks++;
            if (bus.comp_u !== e.compU || bus.comp_v !== e.compV ||
                bus.hold_en !== e.holdEn || bus.result !== e.result) begin
                numErrors++;
                bad++;
                if (bad <= 5)
                    $display("[TB] FAIL wide[%0d]: got u%b v%b hold%b res %h expected u%b v%b hold%b res %h",
                             i, bus.comp_u, bus.comp_v, bus.hold_en, bus.result,
                             e.compU, e.compV, e.holdEn, e.result);
            end
        end
        numChecks++;
        if (expQueue.size() != 0) begin
            numErrors++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", expQueue.size());
        end
    endtask

    // Run every scenario in order and report
    initial begin
        numChecks = 0;
        numErrors = 0;
        rst = 1'b0;
        test_reset();
        test_counter();
        test_comparators();
        test_result_select();
        test_gating();
        test_priority();
        test_wide_compare();
        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

endmodule
